// File: rtl/buffer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buffer_arbiter_pkg
// Brief    : Shared FSM state type and default sizing for the buffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package buffer_arbiter_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_DEPTH     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : buffer_arbiter_pkg
`default_nettype wire

// File: rtl/buffer_arbiter_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : data_buffer
// Brief    : Small circular FIFO driven by the buffer arbiter strobes.
// Revision : 1.0 - initial release
// ============================================================================
module data_buffer
  import buffer_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 write,
  input  logic                 read,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        occ;
  logic                 do_wr;
  logic                 do_rd;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + AW'(1);
  endfunction

  assign full  = (occ == DEPTH_C);
  assign empty = (occ == '0);
  assign do_wr = write && !full;
  assign do_rd = read && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      data_out <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= write && full;
      if (do_wr) begin
        wptr <= next_ptr(wptr);
      end
      if (do_rd) begin
        rptr     <= next_ptr(rptr);
        data_out <= mem[rptr];
      end
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule : data_buffer
`default_nettype wire

// File: rtl/buffer_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin selector; the pointer moves only on accept.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import buffer_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // ptr == 0 favours requester 0 on a contested cycle.
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (accept && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : buffer_arbiter
// Brief    : Grants one buffer write, read or flush-read per cycle to a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req0,
  input  logic                       req1,
  input  logic [WORD_SIZE-1:0]       data0,
  input  logic [WORD_SIZE-1:0]       data1,
  output logic                       gnt0,
  output logic                       gnt1,
  input  logic                       rd_req,
  output logic                       rd_gnt,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       buf_write,
  output logic                       buf_read,
  output logic [WORD_SIZE-1:0]       buf_data_in,
  input  logic                       buf_full,
  input  logic                       buf_overflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e               state;
  state_e               state_next;
  logic [CW-1:0]        count_next;
  logic                 rw_turn;
  logic [1:0]           arb_gnt;
  logic                 wr_elig;
  logic                 rd_elig;
  logic                 contested;
  logic                 wr_grant;
  logic                 rd_grant;
  logic                 flush_rd;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 strobe_d;
  logic                 full_d;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rstn   (rstn),
    .req    ({req1, req0}),
    .accept (wr_grant),
    .gnt    (arb_gnt)
  );

  // rw_turn == 0 lets the write win the next contested cycle.
  assign wr_elig   = (req0 || req1) && (count < DEPTH_C) && (state == IDLE);
  assign rd_elig   = rd_req && (count != '0) && (state == IDLE);
  assign contested = wr_elig && rd_elig;
  assign wr_grant  = wr_elig && !(contested && rw_turn);
  assign rd_grant  = rd_elig && !(contested && !rw_turn);
  assign flush_rd  = (state == FLUSH) && (count != '0);

  assign gnt0       = wr_grant && arb_gnt[0];
  assign gnt1       = wr_grant && arb_gnt[1];
  assign rd_gnt     = rd_grant;
  assign wr_data    = arb_gnt[1] ? data1 : data0;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign flush_done = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush) state_next = FLUSH;
      // Leave as soon as the final drain read is issued (or nothing to drain).
      FLUSH:   if (count <= ONE_C) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (wr_grant) begin
      count_next = count + ONE_C;
    end else if (rd_grant || flush_rd) begin
      count_next = count - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      count       <= '0;
      rw_turn     <= 1'b0;
      buf_write   <= 1'b0;
      buf_read    <= 1'b0;
      buf_data_in <= '0;
      strobe_d    <= 1'b0;
      full_d      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      buf_write <= wr_grant;
      buf_read  <= rd_grant || flush_rd;
      if (contested) begin
        rw_turn <= ~rw_turn;
      end
      if (wr_grant) begin
        buf_data_in <= wr_data;
      end
      // The buffer's full flag lags our own by one cycle after each strobe.
      strobe_d <= buf_write || buf_read;
      full_d   <= full;
      if (buf_overflow || (strobe_d && (buf_full != full_d))) begin
        err <= 1'b1;
      end
    end
  end

endmodule : buffer_arbiter
`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_arbiter
// Brief    : Directed self-checking bench for buffer_arbiter with data_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_arbiter;

  localparam int WS = 8;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          req0;
  logic          req1;
  logic [WS-1:0] data0;
  logic [WS-1:0] data1;
  logic          gnt0;
  logic          gnt1;
  logic          rd_req;
  logic          rd_gnt;
  logic          flush;
  logic          flush_done;
  logic          buf_write;
  logic          buf_read;
  logic [WS-1:0] buf_data_in;
  logic          buf_full;
  logic          buf_empty;
  logic          buf_overflow;
  logic [WS-1:0] buf_data_out;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  buffer_arbiter #(.WORD_SIZE(WS), .DEPTH(DP)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req0         (req0),
    .req1         (req1),
    .data0        (data0),
    .data1        (data1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rd_req       (rd_req),
    .rd_gnt       (rd_gnt),
    .flush        (flush),
    .flush_done   (flush_done),
    .buf_write    (buf_write),
    .buf_read     (buf_read),
    .buf_data_in  (buf_data_in),
    .buf_full     (buf_full),
    .buf_overflow (buf_overflow),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .err          (err)
  );

  data_buffer #(.WORD_SIZE(WS), .DEPTH(DP)) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .write    (buf_write),
    .read     (buf_read),
    .data_in  (buf_data_in),
    .data_out (buf_data_out),
    .full     (buf_full),
    .empty    (buf_empty),
    .overflow (buf_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    data0  = '0;
    data1  = '0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WS-1:0] wr_vals [3];
    wr_vals = '{8'd51, 8'd14, 8'd128};

    // Reset values
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; flush = 1'b0;
    data0 = '0; data1 = '0;
    tick(); tick();
    check("rst_count",      32'(count),       32'd0);
    check("rst_empty",      32'(empty),       32'd1);
    check("rst_full",       32'(full),        32'd0);
    check("rst_gnt0",       32'(gnt0),        32'd0);
    check("rst_gnt1",       32'(gnt1),        32'd0);
    check("rst_rd_gnt",     32'(rd_gnt),      32'd0);
    check("rst_buf_write",  32'(buf_write),   32'd0);
    check("rst_buf_read",   32'(buf_read),    32'd0);
    check("rst_buf_data",   32'(buf_data_in), 32'd0);
    check("rst_flush_done", 32'(flush_done),  32'd0);
    check("rst_err",        32'(err),         32'd0);
    rstn = 1'b1;

    // Single requester, three writes
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data0 = wr_vals[i];
      #1;
      check("w1_gnt0", 32'(gnt0), 32'd1);
      check("w1_gnt1", 32'(gnt1), 32'd0);
      tick();
      check("w1_buf_write", 32'(buf_write),   32'd1);
      check("w1_buf_data",  32'(buf_data_in), 32'(wr_vals[i]));
      check("w1_count",     32'(count),       32'(i + 1));
    end
    req0 = 1'b0;
    #1;
    check("w1_idle_gnt0", 32'(gnt0), 32'd0);
    tick();
    check("w1_no_write", 32'(buf_write), 32'd0);
    check("w1_count3",   32'(count),     32'd3);
    tick();
    check("w1_buf_full", 32'(buf_full), 32'd0);
    check("w1_err",      32'(err),      32'd0);

    // Both requesters held: round robin until full
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hA0; data1 = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      check("rr_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      tick();
      check("rr_buf_data", 32'(buf_data_in), (i % 2 == 0) ? 32'hA0 : 32'hB1);
      check("rr_count",    32'(count),       32'(i + 1));
    end
    #1;
    check("rr_full",      32'(full), 32'd1);
    check("rr_full_gnt0", 32'(gnt0), 32'd0);
    check("rr_full_gnt1", 32'(gnt1), 32'd0);
    tick();
    check("rr_no_write", 32'(buf_write), 32'd0);
    check("rr_count4",   32'(count),     32'd4);
    check("rr_buf_full", 32'(buf_full),  32'd1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("rr_err", 32'(err), 32'd0);

    // Drain with four reads, fifth refused
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rd_gnt", 32'(rd_gnt), 32'd1);
      tick();
      check("rd_count",    32'(count),    32'(3 - i));
      check("rd_buf_read", 32'(buf_read), 32'd1);
    end
    #1;
    check("rd_fifth_gnt", 32'(rd_gnt), 32'd0);
    check("rd_empty",     32'(empty),  32'd1);
    rd_req = 1'b0;
    tick();
    check("rd_no_read",   32'(buf_read),     32'd0);
    check("rd_last_data", 32'(buf_data_out), 32'hB1);
    check("rd_buf_empty", 32'(buf_empty),    32'd1);

    // Contested write/read alternation from count 2
    do_reset();
    req0 = 1'b1; data0 = 8'h11;
    tick();
    data0 = 8'h22;
    tick();
    check("rw_count_start", 32'(count), 32'd2);
    data0 = 8'h33; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rw_gnt0",   32'(gnt0),   32'(i % 2 == 0));
      check("rw_rd_gnt", 32'(rd_gnt), 32'(i % 2 == 1));
      tick();
      check("rw_count", 32'(count), (i % 2 == 0) ? 32'd3 : 32'd2);
    end
    req0 = 1'b0; rd_req = 1'b0;

    // Flush from count 3, requester held off until IDLE
    req0 = 1'b1; data0 = 8'h44;
    tick();
    req0 = 1'b0;
    check("fl_count_start", 32'(count), 32'd3);
    flush = 1'b1;
    #1;
    check("fl_req_gnt0", 32'(gnt0), 32'd0);
    tick();
    flush = 1'b0; req0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      flush = (k == 1);
      #1;
      check("fl_gnt0",       32'(gnt0),       32'd0);
      check("fl_flush_done", 32'(flush_done), 32'(k == 3));
      check("fl_buf_read",   32'(buf_read),   32'(k >= 1));
      check("fl_count",      32'(count),      32'(3 - k));
      tick();
    end
    #1;
    check("fl_idle_done", 32'(flush_done), 32'd0);
    check("fl_idle_read", 32'(buf_read),   32'd0);
    check("fl_idle_gnt0", 32'(gnt0),       32'd1);
    req0 = 1'b0;

    // Flush with nothing stored
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fe_flush_done", 32'(flush_done), 32'd0);
    check("fe_count",      32'(count),      32'd0);
    tick();
    check("fe_done",    32'(flush_done), 32'd1);
    check("fe_no_read", 32'(buf_read),   32'd0);
    tick();
    check("fe_idle", 32'(flush_done), 32'd0);

    // Reset in the middle of a flush
    req0 = 1'b1; data0 = 8'h55;
    tick();
    data0 = 8'h66;
    tick();
    req0 = 1'b0;
    check("rf_count_start", 32'(count), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("rf_in_flush_count", 32'(count), 32'd2);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rf_count",      32'(count),      32'd0);
    check("rf_no_read",    32'(buf_read),   32'd0);
    check("rf_err",        32'(err),        32'd0);
    check("rf_flush_done", 32'(flush_done), 32'd0);
    tick();
    check("rf_no_read_after", 32'(buf_read), 32'd0);
    req0 = 1'b1;
    #1;
    check("rf_idle_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    tick();
    tick();
    check("final_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_buffer_arbiter
`default_nettype wire
